spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_ctrl_pkg.sv | 19 +
 rtl/spi_xfer_ctrl_if.sv | 25 ++
 rtl/spi_rr_arb.sv | 39 +++
 rtl/spi_xfer_ctrl.sv | 124 ++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and sizes for the SPI transfer controller and its arbiter.
package spi_ctrl_pkg;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;
    // Wide enough for 8 bits * 15 cycles per bit.
    localparam int CNT_W   = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        SHIFT,
        READ,
        CAPT,
        RESP
    } state_t;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request/response bus between the requesters and the SPI transfer controller.
interface spi_xfer_ctrl_if;
    import spi_ctrl_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*BYTE_W-1:0] req_mdata;
    logic [NUM_REQ*BYTE_W-1:0] req_sdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_id;
    logic [BYTE_W-1:0]         rsp_mdata;
    logic [BYTE_W-1:0]         rsp_sdata;

    modport master (
        output req_valid, req_mdata, req_sdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_mdata, rsp_sdata
    );

    modport slave (
        input  req_valid, req_mdata, req_sdata, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_mdata, rsp_sdata
    );

endinterface

// File: rtl/spi_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when the
// caller reports an accepted grant.
module spi_rr_arb
    import spi_ctrl_pkg::*;
(
    input  logic               mclk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant
);

    logic last_q;
    logic last_d;

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences one byte exchange on the SPI top per accepted request:
// load, start, wait out the shift, read back, then hand the result out.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int CYC_PER_BIT = 2
) (
    input  logic              mclk,
    input  logic              reset,
    spi_xfer_ctrl_if.slave    bus,
    output logic              load_master,
    output logic              load_slave,
    output logic              read_master,
    output logic              read_slave,
    output logic              start,
    output logic [BYTE_W-1:0] data_in_master,
    output logic [BYTE_W-1:0] data_in_slave,
    input  logic [BYTE_W-1:0] data_out_master,
    input  logic [BYTE_W-1:0] data_out_slave,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SHIFT_CYC = CNT_W'(8 * CYC_PER_BIT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  mst_q, mst_d;
    logic [BYTE_W-1:0]  slv_q, slv_d;
    logic               id_q, id_d;
    logic [BYTE_W-1:0]  rsp_m_q, rsp_m_d;
    logic [BYTE_W-1:0]  rsp_s_q, rsp_s_d;
    logic [NUM_REQ-1:0] grant;
    logic               hs;

    spi_rr_arb u_arb (
        .mclk   (mclk),
        .reset  (reset),
        .req    (bus.req_valid),
        .update (hs),
        .grant  (grant)
    );

    // Grants are withheld while reset is asserted so every output reads zero.
    assign bus.req_ready = (state_q == IDLE && reset) ? grant : '0;
    assign hs            = |(bus.req_valid & bus.req_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mst_d   = mst_q;
        slv_d   = slv_q;
        id_d    = id_q;
        rsp_m_d = rsp_m_q;
        rsp_s_d = rsp_s_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    mst_d   = grant[1] ? bus.req_mdata[2*BYTE_W-1:BYTE_W] : bus.req_mdata[BYTE_W-1:0];
                    slv_d   = grant[1] ? bus.req_sdata[2*BYTE_W-1:BYTE_W] : bus.req_sdata[BYTE_W-1:0];
                    id_d    = grant[1];
                    state_d = LOAD;
                end
            end
            LOAD:  state_d = START;
            START: begin
                cnt_d   = SHIFT_CYC;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = READ;
                end
            end
            READ:  state_d = CAPT;
            CAPT: begin
                rsp_m_d = data_out_master;
                rsp_s_d = data_out_slave;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mst_q   <= '0;
            slv_q   <= '0;
            id_q    <= 1'b0;
            rsp_m_q <= '0;
            rsp_s_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mst_q   <= mst_d;
            slv_q   <= slv_d;
            id_q    <= id_d;
            rsp_m_q <= rsp_m_d;
            rsp_s_q <= rsp_s_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign load_master    = (state_q == LOAD);
    assign load_slave     = (state_q == LOAD);
    assign start          = (state_q == START);
    assign read_master    = (state_q == READ);
    assign read_slave     = (state_q == READ);
    assign data_in_master = busy ? mst_q : '0;
    assign data_in_slave  = busy ? slv_q : '0;

    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_mdata  = rsp_m_q;
    assign bus.rsp_sdata  = rsp_s_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a behavioural byte-swapping SPI top
// and always-on protocol checks.
module tb_spi_xfer_ctrl;
    import spi_ctrl_pkg::*;

    logic       mclk = 1'b0;
    logic       reset = 1'b0;
    logic       load_master, load_slave, read_master, read_slave, start, busy;
    logic [7:0] data_in_master, data_in_slave;
    logic [7:0] dom = 8'h00;
    logic [7:0] dos = 8'h00;
    logic [7:0] mShift = 8'h00;
    logic [7:0] sShift = 8'h00;

    int   totCnt = 0;
    int   badCnt = 0;
    logic modelLast = 1'b1;
    int   shiftLeft = 0;

    spi_xfer_ctrl_if bus();

    spi_xfer_ctrl #(.CYC_PER_BIT(2)) dut (
        .mclk            (mclk),
        .reset           (reset),
        .bus             (bus),
        .load_master     (load_master),
        .load_slave      (load_slave),
        .read_master     (read_master),
        .read_slave      (read_slave),
        .start           (start),
        .data_in_master  (data_in_master),
        .data_in_slave   (data_in_slave),
        .data_out_master (dom),
        .data_out_slave  (dos),
        .busy            (busy)
    );

    always #5 mclk = ~mclk;

    // Behavioural SPI top: a full exchange swaps the two loaded bytes.
    always @(posedge mclk) begin
        if (load_master) mShift <= data_in_master;
        if (load_slave)  sShift <= data_in_slave;
        if (start) begin
            dom <= sShift;
            dos <= mShift;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totCnt++;
        if (obs !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Protocol checks sampled on every falling edge outside reset.
    always @(negedge mclk) begin
        if (reset) begin
            checkOutput("ldRdOvl", 32'((load_master | load_slave) & (read_master | read_slave)), 32'd0);
            checkOutput("rdyOneHot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            if (busy) checkOutput("rdyBusy", 32'(bus.req_ready), 32'd0);
            if (shiftLeft > 0) begin
                checkOutput("ctlShift", 32'({load_master, load_slave, read_master, read_slave, start}), 32'd0);
                shiftLeft--;
            end else if (start) begin
                shiftLeft = 16;
            end
        end else begin
            shiftLeft = 0;
        end
    end

    // One transaction: request, step through the control pulses, collect the
    // response after rdyDelay cycles of back-pressure.
    task automatic applyStimulus(input logic [1:0] vmask, input logic keepValid,
                                 input logic [15:0] md, input logic [15:0] sd, input int rdyDelay);
        int         expId;
        int         n;
        logic       got;
        logic [7:0] expM, expS;
        if (vmask == 2'b11) expId = modelLast ? 0 : 1;
        else                expId = vmask[1] ? 1 : 0;
        expM = (expId == 1) ? md[15:8] : md[7:0];
        expS = (expId == 1) ? sd[15:8] : sd[7:0];
        bus.req_valid = vmask;
        bus.req_mdata = md;
        bus.req_sdata = sd;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge mclk);
            if (|bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("grantSeen", 32'(got), 32'd1);
        if (!got) begin
            bus.req_valid = 2'b00;
            return;
        end
        checkOutput("grantId", 32'(bus.req_ready), (expId == 1) ? 32'd2 : 32'd1);
        modelLast = (expId == 1);
        @(posedge mclk); #1;
        if (!keepValid) bus.req_valid = 2'b00;
        checkOutput("loadPulse", 32'({load_master, load_slave, start}), 32'b110);
        checkOutput("dinM", 32'(data_in_master), 32'(expM));
        checkOutput("dinS", 32'(data_in_slave), 32'(expS));
        got = 1'b0;
        for (n = 1; n <= 100; n++) begin
            @(posedge mclk); #1;
            if (n == 1)  checkOutput("startPulse", 32'({load_master, start}), 32'b01);
            if (n == 18) checkOutput("readPulse", 32'({read_master, read_slave}), 32'b11);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("rspLatency", 32'(n), 32'd20);
        if (!got) return;
        checkOutput("rspId", 32'(bus.rsp_id), 32'(expId));
        checkOutput("rspM", 32'(bus.rsp_mdata), 32'(expS));
        checkOutput("rspS", 32'(bus.rsp_sdata), 32'(expM));
        for (int i = 0; i < rdyDelay; i++) begin
            @(posedge mclk); #1;
            checkOutput("rspHold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_mdata, bus.rsp_sdata}),
                        32'({1'b1, (expId == 1), expS, expM}));
            checkOutput("ctlHold", 32'({load_master, load_slave, read_master, read_slave, start}), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge mclk); #1;
        bus.rsp_ready = 1'b0;
        checkOutput("rspDrop", 32'({bus.rsp_valid, busy}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       seen;
        logic       got;
        logic [1:0] mask;
        logic [15:0] rmd, rsd;
        bus.req_valid = 2'b11;
        bus.req_mdata = '0;
        bus.req_sdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        checkOutput("rstCtl", 32'({busy, bus.rsp_valid, load_master, load_slave, read_master, read_slave, start}), 32'd0);
        checkOutput("rstRdy", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 2'b00;
        reset = 1'b1;
        @(posedge mclk); #1;

        // Basic transfer on requester 0, then back-pressure on requester 1.
        applyStimulus(2'b01, 1'b0, 16'h00A5, 16'h003C, 0);
        applyStimulus(2'b10, 1'b0, 16'h6600, 16'h9900, 10);

        // Abort in the middle of the shift phase.
        bus.req_valid = 2'b01;
        bus.req_mdata = 16'h0077;
        bus.req_sdata = 16'h0088;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge mclk);
            if (|bus.req_ready) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("abortGrant", 32'(got), 32'd1);
        @(posedge mclk); #1;
        bus.req_valid = 2'b11;
        repeat (6) @(posedge mclk);
        #2;
        checkOutput("preRstBusy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abortCtl", 32'({busy, bus.rsp_valid, load_master, load_slave, read_master, read_slave,
                                     start, bus.req_ready, bus.rsp_id}), 32'd0);
        checkOutput("abortData", 32'({data_in_master, data_in_slave, bus.rsp_mdata, bus.rsp_sdata}), 32'd0);
        bus.req_valid = 2'b00;
        modelLast = 1'b1;
        @(posedge mclk); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge mclk); #1;
            if (bus.rsp_valid || busy) seen = 1'b1;
        end
        checkOutput("noRspAfterAbort", 32'(seen), 32'd0);

        // Both requesters pending throughout: grants alternate 0,1,0,1.
        applyStimulus(2'b11, 1'b1, 16'h5A0F, 16'hC3F0, 0);
        applyStimulus(2'b11, 1'b1, 16'h5A0F, 16'hC3F0, 0);
        applyStimulus(2'b11, 1'b1, 16'h1234, 16'h5678, 1);
        applyStimulus(2'b11, 1'b0, 16'h1234, 16'h5678, 0);

        // Random masks, bytes and response back-pressure.
        for (int k = 0; k < 6; k++) begin
            mask = 2'($urandom_range(1, 3));
            rmd  = 16'($urandom);
            rsd  = 16'($urandom);
            applyStimulus(mask, 1'b0, rmd, rsd, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge mclk);
        $display("test done: total=%0d bad=%0d", totCnt, badCnt);
        $finish;
    end

endmodule
